stopwatch_ctrl: RTL and testbench
=================================

# stopwatch_ctrl

Control and timebase block for the five-digit stopwatch. It turns three user-command pulses (start/stop, lap, clear) into a run/pause/lap state machine and keeps the BCD time count M:SS.cc (minutes 0–9, seconds 0–59, hundredths 0–99). It presents the count as the `minute`, `second` and `m_second` values consumed by the 5-digit dynamic display, and generates the display's `scan` strobe. Commands arrive already debounced and single-cycle from the button front end.

## Interface
- `CLK_HZ`, default 50_000_000: input clock frequency.
- `TICK_HZ`, default 100: count rate, in hundredths of a second.
- `SCAN_HZ`, default 1000: digit-scan strobe rate.
- `clk`, in, 1: single system clock; all logic is on its rising edge.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `start_stop`, in, 1: one-cycle command pulse that toggles run/pause.
- `lap`, in, 1: one-cycle command pulse that freezes or unfreezes the display.
- `clear`, in, 1: one-cycle command pulse that zeroes the count.
- `minute`, out, 4: BCD minutes shown on the display.
- `second`, out, 8: two BCD digits, tens in [7:4].
- `m_second`, out, 8: two BCD hundredths digits, tens in [7:4].
- `scan`, out, 1: one-cycle strobe at SCAN_HZ for the display digit counter.
- `running`, out, 1: high in RUN and LAP.
- `frozen`, out, 1: high in LAP.
- `overflow`, out, 1: one-cycle pulse on the 9:59.99 to 0:00.00 wrap.

## Operation
- States:
  - IDLE: count is zero.
  - RUN: counting; display shows the live count.
  - PAUSE: holding.
  - LAP: counting continues; display holds the value latched at lap entry.
- Transitions:
  - IDLE + start_stop → RUN.
  - RUN + start_stop → PAUSE.
  - RUN + lap → LAP; the live count is latched into the display register.
  - LAP + lap → RUN.
  - LAP + start_stop → PAUSE; the display switches to the live count.
  - PAUSE + start_stop → RUN.
  - PAUSE + clear → IDLE.
  - IDLE + clear → IDLE (no effect).
- Ignored commands: clear in RUN or LAP; lap in IDLE or PAUSE.
- Simultaneous pulses: clear wins over start_stop, which wins over lap. Only the winning command is acted on.
- Prescaler:
  - Counts 0 to DIV−1, where DIV = CLK_HZ/TICK_HZ. It emits an internal tick at DIV−1 while in RUN or LAP.
  - Holds its value in PAUSE, so pause/resume keeps the sub-tick fraction.
  - Is zeroed in IDLE and on clear.
- BCD count on each tick:
  - Hundredths unit digit 9 → 0 carries to the tens digit; hundredths 99 → 00 carries to seconds.
  - Seconds 59 → 00 carries to minutes.
  - Minutes 9 → 0 on 9:59.99. The count keeps running and `overflow` pulses in the same cycle as that tick.
  - Digit values above 9 (tens of seconds above 5) are never produced.
- Scan divider:
  - Free-running counter 0 to CLK_HZ/SCAN_HZ − 1, pulsing `scan` at the terminal value.
  - Runs in every state, so the display refreshes in IDLE and PAUSE.
  - Does not react to commands.

## Timing
- Reset (`rst_n` low at a clock edge) forces:
  - state IDLE, all count digits 0, display register 0, prescaler 0, scan divider 0;
  - `running`, `frozen`, `overflow` and `scan` all 0.
- Reset overrides every command in the same cycle. Reset mid-run leaves no residue.
- Command latency: a pulse sampled at edge N changes state, `running` and `frozen` after edge N.
- The first tick after IDLE → RUN occurs DIV cycles after the start_stop edge.
- Count latency: a tick at edge N updates the count after edge N; the output reflects it in the same cycle.
- Lap entry: the value latched is the count after edge N. If a tick coincides with the lap pulse, the latched value includes that tick.
- Outputs are registered, or a mux of registers selected by state; no combinational path exists from command inputs to outputs.

## Structure
- Shared package `stopwatch_pkg`:
  - state enum {IDLE, RUN, PAUSE, LAP};
  - BCD limit constants (9, 5);
  - digit-width localparams.
- Sub-module `bcd_time_counter`:
  - inputs `clk`, `rst_n`, `clr`, `tick`;
  - outputs the three BCD fields and `wrap`.
- The FSM, prescaler, scan divider and lap register stay in `stopwatch_ctrl`.
- Divider widths are computed with $clog2 from the parameters.

## Test plan
All scenarios use CLK_HZ=1000, TICK_HZ=100, SCAN_HZ=250, giving DIV=10 and a scan period of 4.
- Reset then idle for 40 cycles → count stays 0:00.00 and `running` stays 0; `scan` pulses exactly every 4 cycles.
- start_stop, wait 1000 cycles → m_second=8'h00, second=8'h01, minute=0 (100 ticks); `running`=1.
- RUN for 55 cycles, start_stop, idle 100 cycles, start_stop, run 45 cycles → count = 0:00.10, showing the prescaler fraction is preserved. Then clear while running → ignored.
- In RUN at 0:00.20, lap → display holds 0:00.20 for 200 cycles while `frozen`=1. Then lap → display shows 0:00.40.
- Preload near wrap by running 59 999 ticks, one more tick → 0:00.00 with a single-cycle `overflow`. Also: start_stop and clear asserted together in PAUSE → state IDLE, count zero.
- `rst_n` low for one cycle mid-RUN at 0:03.47 → next cycle all outputs 0 and state IDLE.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch control block.
package stopwatch_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned PAIR_W  = 2 * DIGIT_W;
    localparam int unsigned TIME_W  = DIGIT_W + 2 * PAIR_W;

    localparam logic [DIGIT_W-1:0] BCD_DIGIT_MAX    = DIGIT_W'(9);
    localparam logic [DIGIT_W-1:0] BCD_TENS_SEC_MAX = DIGIT_W'(5);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE,
        LAP
    } sw_state_e;

    // Display-ordered time value M:SS.cc
    typedef struct packed {
        logic [DIGIT_W-1:0] minute;
        logic [PAIR_W-1:0]  second;
        logic [PAIR_W-1:0]  m_second;
    } sw_time_t;

endpackage

// File: rtl/bcd_time_counter.sv
// BCD M:SS.cc counter advanced by a tick; pulses wrap on the 9:59.99 rollover.
module bcd_time_counter
    import stopwatch_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               tick,
    output logic [DIGIT_W-1:0] minute,
    output logic [PAIR_W-1:0]  second,
    output logic [PAIR_W-1:0]  m_second,
    output logic               wrap
);

    logic [DIGIT_W-1:0] cs_lo_q, cs_hi_q, s_lo_q, s_hi_q, min_q;
    logic               wrap_q;
    logic               at_max_c;

    assign at_max_c = (cs_lo_q == BCD_DIGIT_MAX) && (cs_hi_q == BCD_DIGIT_MAX) &&
                      (s_lo_q == BCD_DIGIT_MAX) && (s_hi_q == BCD_TENS_SEC_MAX) &&
                      (min_q == BCD_DIGIT_MAX);

    // Ripple carry through the five digits on each tick
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            cs_lo_q <= '0;
            cs_hi_q <= '0;
            s_lo_q  <= '0;
            s_hi_q  <= '0;
            min_q   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            wrap_q <= tick && at_max_c;
            if (tick) begin
                if (cs_lo_q != BCD_DIGIT_MAX) begin
                    cs_lo_q <= cs_lo_q + DIGIT_W'(1);
                end else begin
                    cs_lo_q <= '0;
                    if (cs_hi_q != BCD_DIGIT_MAX) begin
                        cs_hi_q <= cs_hi_q + DIGIT_W'(1);
                    end else begin
                        cs_hi_q <= '0;
                        if (s_lo_q != BCD_DIGIT_MAX) begin
                            s_lo_q <= s_lo_q + DIGIT_W'(1);
                        end else begin
                            s_lo_q <= '0;
                            if (s_hi_q != BCD_TENS_SEC_MAX) begin
                                s_hi_q <= s_hi_q + DIGIT_W'(1);
                            end else begin
                                s_hi_q <= '0;
                                if (min_q != BCD_DIGIT_MAX) begin
                                    min_q <= min_q + DIGIT_W'(1);
                                end else begin
                                    min_q <= '0;
                                end
                            end
                        end
                    end
                end
            end
        end
    end

    assign minute   = min_q;
    assign second   = {s_hi_q, s_lo_q};
    assign m_second = {cs_hi_q, cs_lo_q};
    assign wrap     = wrap_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch command FSM, tick prescaler, lap hold register and display scan strobe.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 50_000_000,
    parameter int unsigned TICK_HZ = 100,
    parameter int unsigned SCAN_HZ = 1000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_stop,
    input  logic               lap,
    input  logic               clear,
    output logic [DIGIT_W-1:0] minute,
    output logic [PAIR_W-1:0]  second,
    output logic [PAIR_W-1:0]  m_second,
    output logic               scan,
    output logic               running,
    output logic               frozen,
    output logic               overflow
);

    localparam int unsigned DIV    = CLK_HZ / TICK_HZ;
    localparam int unsigned SDIV   = CLK_HZ / SCAN_HZ;
    localparam int unsigned PRE_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned SCAN_W = (SDIV > 1) ? $clog2(SDIV) : 1;
    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(DIV - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SDIV - 1);

    sw_state_e          state_q, state_d;
    logic               clear_act_c;
    logic               counting_c;
    logic               tick_c;
    logic [PRE_W-1:0]   presc_q;
    logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
    logic               scan_q;
    logic               running_q, frozen_q, lap_load_q;
    logic [DIGIT_W-1:0] live_min;
    logic [PAIR_W-1:0]  live_sec, live_cs;
    logic               wrap;
    sw_time_t           live_c, lap_q, disp_c;

    // Raw command priority: clear, then start_stop, then lap
    always_comb begin
        state_d     = state_q;
        clear_act_c = 1'b0;
        if (clear) begin
            if (state_q == PAUSE || state_q == IDLE) begin
                state_d     = IDLE;
                clear_act_c = 1'b1;
            end
        end else if (start_stop) begin
            case (state_q)
                IDLE:    state_d = RUN;
                RUN:     state_d = PAUSE;
                LAP:     state_d = PAUSE;
                PAUSE:   state_d = RUN;
                default: state_d = IDLE;
            endcase
        end else if (lap) begin
            if (state_q == RUN) begin
                state_d = LAP;
            end else if (state_q == LAP) begin
                state_d = RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            running_q  <= 1'b0;
            frozen_q   <= 1'b0;
            lap_load_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            running_q  <= (state_d == RUN) || (state_d == LAP);
            frozen_q   <= (state_d == LAP);
            lap_load_q <= (state_d == LAP) && (state_q != LAP);
        end
    end

    assign counting_c = (state_q == RUN) || (state_q == LAP);
    assign tick_c     = counting_c && (presc_q == PRE_LAST);

    // Prescaler holds in PAUSE so resume keeps the sub-tick fraction
    always_ff @(posedge clk) begin
        if (!rst_n || clear_act_c || state_q == IDLE) begin
            presc_q <= '0;
        end else if (counting_c) begin
            presc_q <= tick_c ? '0 : presc_q + PRE_W'(1);
        end
    end

    assign scan_cnt_d = (scan_cnt_q == SCAN_LAST) ? '0 : scan_cnt_q + SCAN_W'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scan_cnt_q <= '0;
            scan_q     <= 1'b0;
        end else begin
            scan_cnt_q <= scan_cnt_d;
            scan_q     <= (scan_cnt_d == SCAN_LAST);
        end
    end

    bcd_time_counter u_time (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clear_act_c),
        .tick     (tick_c),
        .minute   (live_min),
        .second   (live_sec),
        .m_second (live_cs),
        .wrap     (wrap)
    );

    assign live_c = {live_min, live_sec, live_cs};

    // Capture one cycle after LAP entry so a coincident tick is included
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lap_q <= '0;
        end else if (state_q != LAP || lap_load_q) begin
            lap_q <= live_c;
        end
    end

    assign disp_c   = (frozen_q && !lap_load_q) ? lap_q : live_c;
    assign minute   = disp_c.minute;
    assign second   = disp_c.second;
    assign m_second = disp_c.m_second;
    assign scan     = scan_q;
    assign running  = running_q;
    assign frozen   = frozen_q;
    assign overflow = wrap;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl: a DIV=10 instance plus a DIV=1 instance for the wrap.
module tb_stopwatch_ctrl;

    logic       clk;
    logic       rst_n, start_stop, lap, clear;
    logic [3:0] minute;
    logic [7:0] second, m_second;
    logic       scan, running, frozen, overflow;

    logic       rst_n2, start_stop2, lap2, clear2;
    logic [3:0] minute2;
    logic [7:0] second2, m_second2;
    logic       scan2, running2, frozen2, overflow2;

    int n_checks = 0;
    int n_fail   = 0;

    stopwatch_ctrl #(.CLK_HZ(1000), .TICK_HZ(100), .SCAN_HZ(250)) dut (
        .clk(clk), .rst_n(rst_n), .start_stop(start_stop), .lap(lap), .clear(clear),
        .minute(minute), .second(second), .m_second(m_second), .scan(scan),
        .running(running), .frozen(frozen), .overflow(overflow)
    );

    stopwatch_ctrl #(.CLK_HZ(100), .TICK_HZ(100), .SCAN_HZ(25)) dut_fast (
        .clk(clk), .rst_n(rst_n2), .start_stop(start_stop2), .lap(lap2), .clear(clear2),
        .minute(minute2), .second(second2), .m_second(m_second2), .scan(scan2),
        .running(running2), .frozen(frozen2), .overflow(overflow2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected display value for a given number of elapsed hundredths
    function automatic logic [19:0] exp_time(input int t);
        int mn, sc, cs;
        mn = (t / 6000) % 10;
        sc = (t / 100) % 60;
        cs = t % 100;
        return {4'(mn), 4'(sc / 10), 4'(sc % 10), 4'(cs / 10), 4'(cs % 10)};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic ss, input logic lp, input logic cl);
        start_stop = ss; lap = lp; clear = cl;
        step(1);
        start_stop = 1'b0; lap = 1'b0; clear = 1'b0;
    endtask

    task automatic pulse2(input logic ss, input logic lp, input logic cl);
        start_stop2 = ss; lap2 = lp; clear2 = cl;
        step(1);
        start_stop2 = 1'b0; lap2 = 1'b0; clear2 = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        int scans;
        logic [19:0] got;
        rst_n = 1'b0;
        step(2);
        got = {minute, second, m_second};
        n_checks++; if (got !== 20'h0) begin n_fail++; $display("FAIL reset_time: got %h expected %h", got, 20'h0); end
        n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL reset_running: got %b expected 0", running); end
        n_checks++; if (frozen !== 1'b0) begin n_fail++; $display("FAIL reset_frozen: got %b expected 0", frozen); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        n_checks++; if (scan !== 1'b0) begin n_fail++; $display("FAIL reset_scan: got %b expected 0", scan); end
        rst_n = 1'b1;
        scans = 0;
        for (int k = 1; k <= 40; k++) begin
            step(1);
            got = {minute, second, m_second};
            if (scan === 1'b1) scans++;
            n_checks++; if (got !== 20'h0) begin n_fail++; $display("FAIL idle_time cyc %0d: got %h expected %h", k, got, 20'h0); end
            n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL idle_running cyc %0d: got %b expected 0", k, running); end
            n_checks++; if (scan !== ((k % 4) == 3)) begin n_fail++; $display("FAIL idle_scan cyc %0d: got %b expected %b", k, scan, (k % 4) == 3); end
        end
        n_checks++; if (scans != 10) begin n_fail++; $display("FAIL scan_count: got %0d expected 10", scans); end
    endtask

    task automatic test_run();
        logic [19:0] got;
        do_reset();
        pulse(1'b1, 1'b0, 1'b0);
        step(9);
        got = {minute, second, m_second};
        n_checks++; if (got !== exp_time(0)) begin n_fail++; $display("FAIL run_pre_tick: got %h expected %h", got, exp_time(0)); end
        step(1);
        got = {minute, second, m_second};
        n_checks++; if (got !== exp_time(1)) begin n_fail++; $display("FAIL run_first_tick: got %h expected %h", got, exp_time(1)); end
        step(990);
        got = {minute, second, m_second};
        n_checks++; if (got !== 20'h0_01_00) begin n_fail++; $display("FAIL run_1000: got %h expected %h", got, 20'h0_01_00); end
        n_checks++; if (running !== 1'b1) begin n_fail++; $display("FAIL run_running: got %b expected 1", running); end
        n_checks++; if (frozen !== 1'b0) begin n_fail++; $display("FAIL run_frozen: got %b expected 0", frozen); end
    endtask

    task automatic test_pause();
        logic [19:0] got;
        do_reset();
        pulse(1'b1, 1'b0, 1'b0);
        step(55);
        pulse(1'b1, 1'b0, 1'b0);
        step(100);
        got = {minute, second, m_second};
        n_checks++; if (got !== exp_time(5)) begin n_fail++; $display("FAIL pause_hold: got %h expected %h", got, exp_time(5)); end
        n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL pause_running: got %b expected 0", running); end
        pulse(1'b1, 1'b0, 1'b0);
        step(45);
        got = {minute, second, m_second};
        n_checks++; if (got !== exp_time(10)) begin n_fail++; $display("FAIL pause_fraction: got %h expected %h", got, exp_time(10)); end
        pulse(1'b0, 1'b0, 1'b1);
        got = {minute, second, m_second};
        n_checks++; if (got !== exp_time(10)) begin n_fail++; $display("FAIL clear_in_run: got %h expected %h", got, exp_time(10)); end
        n_checks++; if (running !== 1'b1) begin n_fail++; $display("FAIL clear_in_run_running: got %b expected 1", running); end
    endtask

    task automatic test_lap();
        logic [19:0] got;
        do_reset();
        pulse(1'b1, 1'b0, 1'b0);
        step(199);
        got = {minute, second, m_second};
        n_checks++; if (got !== exp_time(19)) begin n_fail++; $display("FAIL lap_pre: got %h expected %h", got, exp_time(19)); end
        pulse(1'b0, 1'b1, 1'b0);
        got = {minute, second, m_second};
        n_checks++; if (got !== exp_time(20)) begin n_fail++; $display("FAIL lap_entry: got %h expected %h", got, exp_time(20)); end
        n_checks++; if (frozen !== 1'b1) begin n_fail++; $display("FAIL lap_frozen: got %b expected 1", frozen); end
        n_checks++; if (running !== 1'b1) begin n_fail++; $display("FAIL lap_running: got %b expected 1", running); end
        step(10);
        got = {minute, second, m_second};
        n_checks++; if (got !== exp_time(20)) begin n_fail++; $display("FAIL lap_hold_10: got %h expected %h", got, exp_time(20)); end
        step(190);
        got = {minute, second, m_second};
        n_checks++; if (got !== exp_time(20)) begin n_fail++; $display("FAIL lap_hold_200: got %h expected %h", got, exp_time(20)); end
        n_checks++; if (frozen !== 1'b1) begin n_fail++; $display("FAIL lap_frozen_200: got %b expected 1", frozen); end
        pulse(1'b0, 1'b1, 1'b0);
        got = {minute, second, m_second};
        n_checks++; if (got !== exp_time(40)) begin n_fail++; $display("FAIL lap_exit: got %h expected %h", got, exp_time(40)); end
        n_checks++; if (frozen !== 1'b0) begin n_fail++; $display("FAIL lap_exit_frozen: got %b expected 0", frozen); end
    endtask

    task automatic test_priority();
        logic [19:0] got;
        do_reset();
        pulse(1'b1, 1'b1, 1'b0);
        n_checks++; if (running !== 1'b1 || frozen !== 1'b0) begin n_fail++; $display("FAIL prio_idle_ss_lap: got run=%b frz=%b expected run=1 frz=0", running, frozen); end
        step(5);
        pulse(1'b1, 1'b1, 1'b0);
        n_checks++; if (running !== 1'b0 || frozen !== 1'b0) begin n_fail++; $display("FAIL prio_run_ss_lap: got run=%b frz=%b expected run=0 frz=0", running, frozen); end
        pulse(1'b0, 1'b1, 1'b0);
        n_checks++; if (frozen !== 1'b0 || running !== 1'b0) begin n_fail++; $display("FAIL lap_in_pause: got run=%b frz=%b expected run=0 frz=0", running, frozen); end
        pulse(1'b1, 1'b1, 1'b1);
        step(20);
        got = {minute, second, m_second};
        n_checks++; if (running !== 1'b0 || got !== 20'h0) begin n_fail++; $display("FAIL prio_clear: got run=%b time=%h expected run=0 time=%h", running, got, 20'h0); end
    endtask

    task automatic test_wrap();
        logic [19:0] got;
        rst_n2 = 1'b0;
        step(1);
        rst_n2 = 1'b1;
        pulse2(1'b1, 1'b0, 1'b0);
        step(59998);
        got = {minute2, second2, m_second2};
        n_checks++; if (got !== exp_time(59998)) begin n_fail++; $display("FAIL wrap_pre2: got %h expected %h", got, exp_time(59998)); end
        step(1);
        got = {minute2, second2, m_second2};
        n_checks++; if (got !== 20'h9_59_99) begin n_fail++; $display("FAIL wrap_max: got %h expected %h", got, 20'h9_59_99); end
        n_checks++; if (overflow2 !== 1'b0) begin n_fail++; $display("FAIL wrap_ovf_early: got %b expected 0", overflow2); end
        step(1);
        got = {minute2, second2, m_second2};
        n_checks++; if (got !== 20'h0) begin n_fail++; $display("FAIL wrap_zero: got %h expected %h", got, 20'h0); end
        n_checks++; if (overflow2 !== 1'b1) begin n_fail++; $display("FAIL wrap_ovf: got %b expected 1", overflow2); end
        step(1);
        got = {minute2, second2, m_second2};
        n_checks++; if (got !== exp_time(1)) begin n_fail++; $display("FAIL wrap_after: got %h expected %h", got, exp_time(1)); end
        n_checks++; if (overflow2 !== 1'b0) begin n_fail++; $display("FAIL wrap_ovf_single: got %b expected 0", overflow2); end
        pulse2(1'b1, 1'b0, 1'b0);
        step(3);
        got = {minute2, second2, m_second2};
        n_checks++; if (got !== exp_time(2) || running2 !== 1'b0) begin n_fail++; $display("FAIL fast_pause: got run=%b time=%h expected run=0 time=%h", running2, got, exp_time(2)); end
        pulse2(1'b1, 1'b0, 1'b1);
        step(5);
        got = {minute2, second2, m_second2};
        n_checks++; if (got !== 20'h0) begin n_fail++; $display("FAIL pause_ss_clear_time: got %h expected %h", got, 20'h0); end
        n_checks++; if (running2 !== 1'b0) begin n_fail++; $display("FAIL pause_ss_clear_running: got %b expected 0", running2); end
    endtask

    task automatic test_reset_mid_run();
        logic [19:0] got;
        do_reset();
        pulse(1'b1, 1'b0, 1'b0);
        step(3470);
        got = {minute, second, m_second};
        n_checks++; if (got !== 20'h0_03_47) begin n_fail++; $display("FAIL mid_run_time: got %h expected %h", got, 20'h0_03_47); end
        rst_n = 1'b0;
        step(1);
        got = {minute, second, m_second};
        n_checks++; if (got !== 20'h0) begin n_fail++; $display("FAIL mid_reset_time: got %h expected %h", got, 20'h0); end
        n_checks++; if ({running, frozen, overflow, scan} !== 4'b0) begin n_fail++; $display("FAIL mid_reset_flags: got %b expected 0000", {running, frozen, overflow, scan}); end
        rst_n = 1'b1;
        step(20);
        got = {minute, second, m_second};
        n_checks++; if (got !== 20'h0 || running !== 1'b0) begin n_fail++; $display("FAIL mid_reset_idle: got run=%b time=%h expected run=0 time=%h", running, got, 20'h0); end
        pulse(1'b1, 1'b0, 1'b0);
        step(9);
        got = {minute, second, m_second};
        n_checks++; if (got !== exp_time(0)) begin n_fail++; $display("FAIL mid_reset_presc: got %h expected %h", got, exp_time(0)); end
        step(1);
        got = {minute, second, m_second};
        n_checks++; if (got !== exp_time(1)) begin n_fail++; $display("FAIL mid_reset_tick: got %h expected %h", got, exp_time(1)); end
    endtask

    initial begin
        rst_n = 1'b0; start_stop = 1'b0; lap = 1'b0; clear = 1'b0;
        rst_n2 = 1'b0; start_stop2 = 1'b0; lap2 = 1'b0; clear2 = 1'b0;
        test_reset();
        test_run();
        test_pause();
        test_lap();
        test_priority();
        test_reset_mid_run();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
